// File: rtl/gpr_wb_scoreboard_if.sv
// Bundle of issue, ALU, long-result, decode-read and register-file write signals
// around the GPR write-back scoreboard. The slave modport is the scoreboard's view.
interface gpr_wb_scoreboard_if;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lr_valid;
  logic        lr_ready;
  logic [4:0]  lr_rd;
  logic [31:0] lr_data;
  logic [4:0]  rd_addr_0;
  logic [4:0]  rd_addr_1;
  logic        hazard_0;
  logic        hazard_1;
  logic [4:0]  wr_addr;
  logic        we;
  logic [31:0] wr_data;
  logic        sb_err;

  modport master (
    output issue_valid, issue_rd, alu_we, alu_rd, alu_data,
           lr_valid, lr_rd, lr_data, rd_addr_0, rd_addr_1,
    input  issue_ready, lr_ready, hazard_0, hazard_1,
           wr_addr, we, wr_data, sb_err
  );

  modport slave (
    input  issue_valid, issue_rd, alu_we, alu_rd, alu_data,
           lr_valid, lr_rd, lr_data, rd_addr_0, rd_addr_1,
    output issue_ready, lr_ready, hazard_0, hazard_1,
           wr_addr, we, wr_data, sb_err
  );
endinterface

// File: rtl/gpr_wb_scoreboard.sv
// Register-file write-port arbiter: ALU results take priority, long-latency results
// queue in a small FIFO, and a pending-bit scoreboard reports hazards and blocks WAW issue.
module gpr_wb_scoreboard #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned PTR_W      = $clog2(FIFO_DEPTH)
) (
  input logic                 clk,
  input logic                 rst_n,
  gpr_wb_scoreboard_if.slave  bus
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  logic [4:0]       fifo_rd   [FIFO_DEPTH];
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic [31:0]      pending;
  logic [31:0]      pending_nxt;

  logic             alu_sel;
  logic             push;
  logic             pop;
  logic             issue_acc;
  logic [4:0]       head_rd;
  logic [31:0]      head_data;
  logic             err_nxt;

  assign head_rd   = fifo_rd[head];
  assign head_data = fifo_data[head];

  assign alu_sel   = bus.alu_we && (bus.alu_rd != 5'd0);
  assign pop       = !alu_sel && (count != '0);
  assign bus.lr_ready = (count < DEPTH_C);
  assign push      = bus.lr_valid && bus.lr_ready;

  // pending[0] is held at zero, so r0 is always issue-ready and never a hazard.
  assign bus.issue_ready = !pending[bus.issue_rd];
  assign issue_acc       = bus.issue_valid && bus.issue_ready && (bus.issue_rd != 5'd0);
  assign bus.hazard_0    = pending[bus.rd_addr_0];
  assign bus.hazard_1    = pending[bus.rd_addr_1];

  always_comb begin
    pending_nxt = pending;
    if (pop) pending_nxt[head_rd] = 1'b0;
    if (issue_acc) pending_nxt[bus.issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_comb begin
    err_nxt = bus.sb_err;
    if (alu_sel && pending[bus.alu_rd]) err_nxt = 1'b1;
    if (pop && (head_rd != 5'd0) && !pending[head_rd]) err_nxt = 1'b1;
  end

  // Storage needs no reset: validity is carried entirely by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail]   <= bus.lr_rd;
      fifo_data[tail] <= bus.lr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W + 1)'(1);
      else if (pop && !push) count <= count - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      bus.sb_err <= 1'b0;
    end else begin
      pending    <= pending_nxt;
      bus.sb_err <= err_nxt;
    end
  end

  // A popped r0 result is discarded: we drops and the address/data hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.we      <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else if (alu_sel) begin
      bus.we      <= 1'b1;
      bus.wr_addr <= bus.alu_rd;
      bus.wr_data <= bus.alu_data;
    end else if (pop && (head_rd != 5'd0)) begin
      bus.we      <= 1'b1;
      bus.wr_addr <= head_rd;
      bus.wr_data <= head_data;
    end else begin
      bus.we      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpr_wb_scoreboard.sv
// Directed and randomized check of gpr_wb_scoreboard against a queue-based
// model of the write-back rules.
module tb_gpr_wb_scoreboard;
  localparam int unsigned DEPTH = 2;

  logic clk;
  logic rst_n;
  gpr_wb_scoreboard_if bus ();

  gpr_wb_scoreboard #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  int checks   = 0;
  int failures = 0;

  ent_t        mq[$];
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_err;
  logic        m_acc;
  logic        m_iss;
  logic [4:0]  outq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend = '0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_err  = 1'b0;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.alu_we = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lr_valid = 1'b0; bus.lr_rd = '0; bus.lr_data = '0;
    bus.rd_addr_0 = '0; bus.rd_addr_1 = '0;
  endtask

  // One clock: check the combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    ent_t h;
    #1;
    chk("issue_ready", bus.issue_ready, (bus.issue_rd == 0) ? 1 : !m_pend[bus.issue_rd]);
    chk("lr_ready", bus.lr_ready, mq.size() < DEPTH);
    chk("hazard_0", bus.hazard_0, (bus.rd_addr_0 == 0) ? 0 : m_pend[bus.rd_addr_0]);
    chk("hazard_1", bus.hazard_1, (bus.rd_addr_1 == 0) ? 0 : m_pend[bus.rd_addr_1]);
    m_acc = bus.lr_valid && (mq.size() < DEPTH);
    m_iss = bus.issue_valid && (bus.issue_rd != 0) && !m_pend[bus.issue_rd];
    if (bus.alu_we && bus.alu_rd != 0) begin
      if (m_pend[bus.alu_rd]) m_err = 1'b1;
      m_we = 1'b1; m_addr = bus.alu_rd; m_data = bus.alu_data;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      if (h.rd != 0) begin
        if (!m_pend[h.rd]) m_err = 1'b1;
        m_pend[h.rd] = 1'b0;
        m_we = 1'b1; m_addr = h.rd; m_data = h.data;
      end else m_we = 1'b0;
    end else m_we = 1'b0;
    if (m_iss) m_pend[bus.issue_rd] = 1'b1;
    if (m_acc) mq.push_back('{rd: bus.lr_rd, data: bus.lr_data});
    @(posedge clk);
    #1;
    chk("we", bus.we, m_we);
    chk("wr_addr", bus.wr_addr, m_addr);
    chk("wr_data", bus.wr_data, m_data);
    chk("sb_err", bus.sb_err, m_err);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    idle();
    #1;
    chk("arst_we", bus.we, 0);
    chk("arst_addr", bus.wr_addr, 0);
    chk("arst_lr_ready", bus.lr_ready, 1);
    chk("arst_err", bus.sb_err, 0);
    model_reset();
    outq.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();

    // Reset held with traffic toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.issue_valid = 1'b1; bus.issue_rd = 5'($urandom_range(1, 31));
      bus.alu_we = 1'b1; bus.alu_rd = 5'($urandom_range(1, 31)); bus.alu_data = $urandom;
      bus.lr_valid = 1'b1; bus.lr_rd = bus.issue_rd; bus.lr_data = $urandom;
      bus.rd_addr_0 = bus.issue_rd; bus.rd_addr_1 = bus.alu_rd;
      #1;
      chk("rst_we", bus.we, 0);
      chk("rst_lr_ready", bus.lr_ready, 1);
      chk("rst_issue_ready", bus.issue_ready, 1);
      chk("rst_hazard_0", bus.hazard_0, 0);
      chk("rst_hazard_1", bus.hazard_1, 0);
      chk("rst_sb_err", bus.sb_err, 0);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First ALU write
    bus.alu_we = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
    cycle();
    chk("alu5_we", bus.we, 1);
    chk("alu5_addr", bus.wr_addr, 5);
    chk("alu5_data", bus.wr_data, 32'h1234);
    idle(); cycle();

    // Long op to r7
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    cycle();
    idle(); bus.rd_addr_0 = 5'd7; bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    #1;
    chk("r7_hazard", bus.hazard_0, 1);
    chk("r7_issue_blocked", bus.issue_ready, 0);
    cycle();
    bus.issue_valid = 1'b0;
    bus.lr_valid = 1'b1; bus.lr_rd = 5'd7; bus.lr_data = 32'hDEADBEEF;
    cycle();
    bus.lr_valid = 1'b0;
    chk("r7_not_passthru", bus.we, 0);
    cycle();
    chk("r7_we", bus.we, 1);
    chk("r7_addr", bus.wr_addr, 7);
    chk("r7_data", bus.wr_data, 32'hDEADBEEF);
    chk("r7_hazard_drop", bus.hazard_0, 0);
    idle(); cycle();

    // ALU starves the FIFO while two long results arrive
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3; cycle();
    bus.issue_rd = 5'd4; cycle();
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.alu_we = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h9000 + i;
      bus.lr_valid = (i < 2); bus.lr_rd = (i == 0) ? 5'd3 : 5'd4;
      bus.lr_data = (i == 0) ? 32'h3333_0003 : 32'h4444_0004;
      cycle();
      chk("col_alu_we", bus.wr_addr, 9);
    end
    idle(); #1;
    chk("col_full", bus.lr_ready, 0);
    cycle();
    chk("col_first", bus.wr_addr, 3);
    chk("col_first_data", bus.wr_data, 32'h3333_0003);
    cycle();
    chk("col_second", bus.wr_addr, 4);
    chk("col_second_data", bus.wr_data, 32'h4444_0004);
    cycle();
    chk("col_drain", bus.we, 0);

    // r0 handling
    bus.alu_we = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hBAD0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.rd_addr_0 = 5'd0;
    cycle();
    chk("r0_alu_no_we", bus.we, 0);
    idle();
    bus.lr_valid = 1'b1; bus.lr_rd = 5'd0; bus.lr_data = 32'hBAD1;
    cycle();
    idle(); cycle();
    chk("r0_lr_no_we", bus.we, 0);
    cycle();

    // Error paths
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd10; cycle();
    idle(); bus.alu_we = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'hAAAA;
    cycle();
    chk("waw_err", bus.sb_err, 1);
    chk("waw_write", bus.wr_addr, 10);
    idle(); cycle();
    do_reset();
    chk("err_cleared", bus.sb_err, 0);
    bus.lr_valid = 1'b1; bus.lr_rd = 5'd12; bus.lr_data = 32'h1200;
    cycle();
    idle(); cycle();
    chk("stray_err", bus.sb_err, 1);
    do_reset();

    // Mid-operation reset with a full FIFO and pending bits
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3; cycle();
    bus.issue_rd = 5'd4; cycle();
    idle();
    bus.alu_we = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    bus.lr_valid = 1'b1; bus.lr_rd = 5'd3; bus.lr_data = 32'h33; cycle();
    bus.lr_rd = 5'd4; bus.lr_data = 32'h44; cycle();
    bus.lr_valid = 1'b0; cycle();
    chk("mid_busy", bus.we, 1);
    do_reset();
    bus.rd_addr_0 = 5'd3; bus.rd_addr_1 = 5'd4;
    for (int i = 0; i < 4; i++) cycle();

    // Randomized legal traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [4:0] r;
      idle();
      bus.issue_valid = ($urandom_range(0, 2) == 0);
      bus.issue_rd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        r = 5'($urandom_range(0, 31));
        if (!m_pend[r]) begin
          bus.alu_we = 1'b1; bus.alu_rd = r; bus.alu_data = $urandom;
        end
      end
      if (outq.size() > 0 && $urandom_range(0, 1) == 1) begin
        bus.lr_valid = 1'b1; bus.lr_rd = outq[0]; bus.lr_data = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.lr_valid = 1'b1; bus.lr_rd = 5'd0; bus.lr_data = $urandom;
      end
      bus.rd_addr_0 = 5'($urandom_range(0, 31));
      bus.rd_addr_1 = 5'($urandom_range(0, 31));
      r = bus.issue_rd;
      cycle();
      if (m_acc && bus.lr_rd != 0) void'(outq.pop_front());
      if (m_iss) outq.push_back(r);
    end
    idle();
    for (int i = 0; i < 4; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpr_wb_scoreboard.md
Name: gpr_wb_scoreboard

Overview:
- Writer side of the CPU general-purpose register file. Merges single-cycle ALU results and long-latency results (load/mul/div) into the file's single write port (wr_addr/we/wr_data).
- Tracks destination registers of in-flight long-latency ops in a 32-bit scoreboard. Reports read hazards to decode and blocks WAW issue.
- Sits between execute/memory stages and the register file write port.

Parameters:
FIFO_DEPTH, 2, long-result buffer entries; power of two, >=2
PTR_W, 1, log2(FIFO_DEPTH)

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
issue_valid  in  1  long-latency op issued this cycle
issue_rd  in  5  destination of issued op
issue_ready  out  1  issue accepted (destination not pending)
alu_we  in  1  ALU result valid
alu_rd  in  5  ALU destination
alu_data  in  32  ALU result
lr_valid  in  1  long result valid
lr_ready  out  1  long result accepted
lr_rd  in  5  long result destination
lr_data  in  32  long result data
rd_addr_0  in  5  decode read address, port 0
rd_addr_1  in  5  decode read address, port 1
hazard_0  out  1  rd_addr_0 pending
hazard_1  out  1  rd_addr_1 pending
wr_addr  out  5  to register file write port
we  out  1  to register file write port
wr_data  out  32  to register file write port
sb_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst_n=0): we=0, wr_addr=0, wr_data=0, FIFO empty, pending=0, sb_err=0. Output values hold while rst_n=0. Reset mid-operation discards buffered results and pending bits.
- Write-port outputs are registered. A selected source appears on we/wr_addr/wr_data the cycle after selection; the file writes at the following edge. The file's write-through bypass covers same-cycle reads.
- Writes to r0 are dropped: never selected, never asserted on we.
- Selection each cycle, priority order:
  1. alu_we && alu_rd!=0: ALU wins.
  2. Else, if FIFO is non-empty: pop head and drive it.
  3. Else: we=0 next cycle; wr_addr/wr_data hold.
- ALU is never back-pressured. Continuous ALU writes starve the FIFO, which then back-pressures via lr_ready.
- lr_ready = (count < FIFO_DEPTH), from registered count. There is no pass-through: a long result is written no earlier than 2 cycles after acceptance.
- Push (lr_valid && lr_ready) and pop may occur in the same cycle; count stays unchanged. Pointers wrap modulo FIFO_DEPTH.
- Results with lr_rd=0 are accepted and discarded at pop (no write).
- Scoreboard pending[31:1] (bit 0 tied 0):
  - issue_ready = !pending[issue_rd] (r0 always ready).
  - Set pending[issue_rd] on issue_valid && issue_ready && issue_rd!=0.
  - Clear pending[head.rd] at the edge a FIFO entry is popped. That same edge loads the output register, so the hazard drops in the cycle we=1 for that register.
  - Set and clear of the same bit in one cycle cannot occur, because issue_ready masks it.
- hazard_n = pending[rd_addr_n], combinational from registered state; r0 is never a hazard.
- sb_err is set, sticky until reset, on either:
  - alu_we to a register with pending=1 (WAW violation by decode); the ALU write still proceeds and the pending bit is unchanged.
  - popping a long result to rd!=0 whose pending bit is 0.
- Widths: all data 32-bit, no arithmetic on data. count is PTR_W+1 bits.

Test Plan:
- Reset: hold rst_n=0 with traffic toggling -> we=0, lr_ready=1, issue_ready=1, hazard_0/1=0, sb_err=0. Release, then alu_we=1, rd=5, data=0x1234 -> we=1, wr_addr=5, wr_data=0x1234 one cycle later.
- Long op: issue rd=7 -> hazard_0=1 for rd_addr_0=7 and issue_ready=0 for a second issue to 7. lr_valid with rd=7, data=0xDEADBEEF -> we=1, addr=7, data=0xDEADBEEF 2 cycles after acceptance; hazard_0=0 in that same cycle.
- Collision: pending rd=3,4; ALU writes rd=9 for 4 consecutive cycles while two long results (rd=3,4) arrive -> both buffered, lr_ready=0 after the second, then written 3 then 4 once ALU idles. No data lost, order preserved.
- r0: alu_we with rd=0, and issue/result with rd=0 -> we never asserted for addr 0; issue_ready=1; hazard for rd_addr=0 is 0.
- Errors: alu_we to pending rd=10 -> sb_err=1 and the write still occurs. Then reset -> sb_err=0. Long result to non-pending rd=12 -> sb_err=1.
- Mid-op reset: FIFO holds 2 entries and pending!=0, assert rst_n=0 -> we=0 immediately, FIFO empty, pending=0, and no stale write after release.
